// File: rtl/lcd_write_engine.sv
// lcd_write_engine: HD44780 write timing engine (setup, enable pulse, hold, execution wait).
// Optional macro FOUR_BIT_MODE_EN selects a 4-bit bus (high nibble then low nibble on LCD_DATA[7:4]).
module lcd_write_engine #(
  parameter int T_SETUP     = 4,
  parameter int T_EN        = 16,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 18
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, DONE} state_t;

  // Each timed state loads T-1 on entry and exits when the counter reaches zero.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_long;
  logic [CNT_W-1:0] exec_load;

`ifdef FOUR_BIT_MODE_EN
  logic [3:0] low_nib;
  logic       second;
`endif

  assign LCD_RW    = 1'b0;
  assign exec_load = is_long ? LD_LONG : LD_EXEC;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      is_long  <= 1'b0;
      LCD_DATA <= 8'h00;
      LCD_RS   <= 1'b0;
      LCD_EN   <= 1'b0;
      oDone    <= 1'b0;
      oBusy    <= 1'b0;
`ifdef FOUR_BIT_MODE_EN
      low_nib  <= 4'h0;
      second   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            LCD_RS  <= iRS;
            oBusy   <= 1'b1;
            // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
            is_long <= ~iRS & (iDATA[7:2] == 6'b0) & (iDATA[1:0] != 2'b0);
            cnt     <= LD_SETUP;
            state   <= SETUP;
`ifdef FOUR_BIT_MODE_EN
            LCD_DATA <= {iDATA[7:4], 4'h0};
            low_nib  <= iDATA[3:0];
            second   <= 1'b0;
`else
            LCD_DATA <= iDATA;
`endif
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state  <= PULSE;
            cnt    <= LD_EN;
            LCD_EN <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state  <= HOLD;
            cnt    <= LD_HOLD;
            LCD_EN <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
`ifdef FOUR_BIT_MODE_EN
            if (!second) begin
              second   <= 1'b1;
              LCD_DATA <= {low_nib, 4'h0};
              cnt      <= LD_SETUP;
              state    <= SETUP;
            end else begin
              state <= EXEC;
              cnt   <= exec_load;
            end
`else
            state <= EXEC;
            cnt   <= exec_load;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            state <= DONE;
            oDone <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Requester must drop iStart before another byte can be accepted.
          if (!iStart) begin
            state <= IDLE;
            oDone <= 1'b0;
            oBusy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: table-driven and randomized checks of lcd_write_engine against a timeline model.
// Honours FOUR_BIT_MODE_EN when the design is built with it.
module tb_lcd_write_engine;
  localparam int TS = 2, TE = 3, TH = 2, TX = 10, TXL = 50;
`ifdef FOUR_BIT_MODE_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  localparam int PH = TS + TE + TH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] iDATA = 8'h00;
  logic       iRS = 1'b0;
  logic       iStart = 1'b0;
  logic       oDone, oBusy, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] LCD_DATA;

  int errors = 0;
  int checks = 0;

  lcd_write_engine #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL), .CNT_W(18)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
    .oDone(oDone), .oBusy(oBusy), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a transaction is a timeline indexed by cycles after the accept edge.
  function automatic bit model_long(logic [7:0] d, logic rs);
    return (rs == 1'b0) && (d >= 8'd1) && (d <= 8'd3);
  endfunction

  function automatic int model_latency(bit lng);
    return NP * PH + (lng ? TXL : TX);
  endfunction

  function automatic logic [7:0] model_bus(logic [7:0] d, int k);
    if (NP == 1) return d;
    return (k < PH) ? {d[7:4], 4'h0} : {d[3:0], 4'h0};
  endfunction

  function automatic bit model_en(int k);
    for (int p = 0; p < NP; p++)
      if (k >= p * PH + TS && k < p * PH + TS + TE) return 1'b1;
    return 1'b0;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(string tag, logic [7:0] d, logic rs, bit lng, int hold, bit jitter, int gap);
    int lat;
    int done_seen;
    int en_bad, bus_bad, rs_bad, busy_bad, done_bad, en_cycles, idle_bad;
    lat = model_latency(lng);
    done_seen = -1;
    en_bad = 0; bus_bad = 0; rs_bad = 0; busy_bad = 0; done_bad = 0; en_cycles = 0; idle_bad = 0;
    iDATA = d; iRS = rs; iStart = 1'b1;
    for (int k = 0; k <= lat + hold; k++) begin
      @(negedge clk);
      if (LCD_EN !== model_en(k)) en_bad++;
      if (LCD_EN === 1'b1) en_cycles++;
      if (LCD_DATA !== model_bus(d, k)) bus_bad++;
      if (LCD_RS !== rs) rs_bad++;
      if (oBusy !== 1'b1) busy_bad++;
      if (oDone !== (k >= lat)) done_bad++;
      if (oDone === 1'b1 && done_seen < 0) done_seen = k;
      if (jitter) begin
        iDATA = 8'($urandom);
        iRS   = 1'($urandom);
        iStart = (k < lat - 1) ? 1'($urandom) : 1'b1;
      end
    end
    check({tag, "_done_at"}, done_seen, lat);
    check({tag, "_en_shape"}, en_bad, 0);
    check({tag, "_en_cycles"}, en_cycles, NP * TE);
    check({tag, "_bus"}, bus_bad, 0);
    check({tag, "_rs"}, rs_bad, 0);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_done_level"}, done_bad, 0);
    iStart = 1'b0;
    @(negedge clk);
    check({tag, "_drop_done"}, oDone, 0);
    check({tag, "_drop_busy"}, oBusy, 0);
    check({tag, "_drop_bus_held"}, LCD_DATA, model_bus(d, lat));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (LCD_EN !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0 || LCD_DATA !== model_bus(d, lat))
        idle_bad++;
    end
    check({tag, "_idle"}, idle_bad, 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       rs;
    bit         lng;
    int         hold;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int bad;
    tbl = '{
      '{8'h41, 1'b1, 1'b0, 20},
      '{8'h01, 1'b0, 1'b1, 0},
      '{8'h01, 1'b1, 1'b0, 0},
      '{8'h02, 1'b0, 1'b1, 2},
      '{8'h03, 1'b0, 1'b1, 0},
      '{8'h00, 1'b0, 1'b0, 0},
      '{8'h04, 1'b0, 1'b0, 1},
      '{8'h38, 1'b0, 1'b0, 0},
      '{8'h82, 1'b0, 1'b0, 0}
    };

    // Reset state, then idle after release.
    repeat (3) @(negedge clk);
    check("rst_data", LCD_DATA, 8'h00);
    check("rst_en", LCD_EN, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_rw", LCD_RW, 0);
    check("rst_done", oDone, 0);
    check("rst_busy", oBusy, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (LCD_DATA !== 8'h00 || LCD_EN !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) bad++;
    end
    check("post_rst_idle", bad, 0);

    foreach (tbl[i]) run_txn($sformatf("vec%0d", i), tbl[i].d, tbl[i].rs, tbl[i].lng, tbl[i].hold, 1'b0, 1);

    // Reset during the second enable-pulse cycle.
    iDATA = 8'h41; iRS = 1'b1; iStart = 1'b1;
    repeat (TS + 2) @(negedge clk);
    check("midrst_en_before", LCD_EN, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_en_async", LCD_EN, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_data", LCD_DATA, 8'h00);
    iStart = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (TXL + 10) begin
      @(negedge clk);
      if (oDone !== 1'b0 || LCD_EN !== 1'b0 || oBusy !== 1'b0) bad++;
    end
    check("midrst_lost", bad, 0);
    run_txn("after_rst", 8'h41, 1'b1, 1'b0, 0, 1'b0, 0);

    // Randomized transactions with input jitter after accept.
    for (int r = 0; r < 25; r++) begin
      logic [7:0] d;
      logic       rs;
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      rs = 1'($urandom);
      run_txn($sformatf("rnd%0d", r), d, rs, model_long(d, rs), $urandom_range(0, 3), 1'b1,
              $urandom_range(0, 3));
    end

    check("final_rw", LCD_RW, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
